alu_writeback: RTL and testbench
================================

// Module: alu_writeback
// PURPOSE
//  Execute->writeback stage directly downstream of the uBio ALU.
//  - Registers one ALU result per accepted op and drives it into the register-file write port through a valid/ready handshake.
//  - For MUL, writes both halves to the register file in two beats.
//  - Holds the architectural flag register {C,V,Z,N}.
// PARAMETERS
//  DATA_W     16  ALU result / register-file data width
//  ADDR_W      4  register-file address width (16 registers)
//  CNT_W      16  width of retired-op counter
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  in_valid    in   1       ALU output (result, flags, opcode, rd) is valid
//  in_ready    out  1       stage can accept this cycle
//  alu_ctl     in   8       opcode that produced the result
//  rd_addr     in   ADDR_W  destination register
//  result      in   DATA_W  ALU low result
//  result2     in   DATA_W  ALU high result (MUL only)
//  c_in,v_in,z_in,n_in in 1 ALU flags
//  wb_valid    out  1       register-file write request
//  wb_ready    in   1       register file accepts write this cycle
//  wb_addr     out  ADDR_W  write address
//  wb_data     out  DATA_W  write data
//  flags       out  4       {C,V,Z,N} architectural flags
//  illegal_op  out  1       sticky: an unknown opcode was accepted
//  retired     out  CNT_W   count of ops fully completed, wraps
// BEHAVIOUR
//  Opcodes:
//  - Writing, flag-loading: ADD 8'h12, SUB 8'h13, MUL 8'h14, ORI 8'h0A, ANDI 8'h0C, ADDI 8'h15.
//  - NOP 8'h00: no write, flags unchanged.
//  - Any other opcode: no write, flags unchanged, illegal_op <= 1.
//  Reset (async, rst_n=0): state=IDLE, wb_valid=0, wb_addr=0, wb_data=0, flags=0, illegal_op=0, retired=0, in_ready=0 while asserted.
//  States:
//  - IDLE: wb_valid=0.
//  - WR_LO: wb_valid=1, wb_addr=rd, wb_data=result.
//  - WR_HI: wb_valid=1, wb_addr=rd+1 (mod 2^ADDR_W, so 15->0), wb_data=result2.
//  in_ready = IDLE | (WR_LO & wb_ready & ~is_mul_held) | (WR_HI & wb_ready).
//  Accept (in_valid & in_ready), on the next edge:
//  - Capture opcode/rd/result/result2 into the hold registers.
//  - Flag-loading ops load flags <= {c_in,v_in,z_in,n_in}.
//  - Writing op -> WR_LO. NOP/unknown -> IDLE, retired+1.
//  Transitions:
//  - WR_LO & wb_ready: MUL -> WR_HI. Otherwise retired+1, then -> WR_LO if a new writing op is accepted the same cycle, else IDLE.
//  - WR_HI & wb_ready: retired+1, then next state per same-cycle accept (WR_LO or IDLE).
//  - wb_valid=0 & wb_ready=1: no effect.
//  Stall rules:
//  - wb_valid & ~wb_ready: wb_addr/wb_data held stable, state held, in_ready=0 (back-pressure to ALU).
//  - in_valid & ~in_ready: nothing captured; inputs must be held by upstream.
//  Latency: accept at edge N -> wb_valid at N+1 (registered, no comb. path result->wb_data).
//  Throughput: 1 op/cycle with wb_ready=1; MUL costs 2 cycles.
//  Same-cycle retire+accept: retired increments once; flags take the new op's values.
//  retired wraps 2^CNT_W-1 -> 0.
//  Reset mid-MUL (any state): pending writes dropped, no partial WR_HI after reset release.
//  illegal_op clears only on reset.
// STRUCTURE
//  Shared package ubio_pkg:
//  - opcode localparams (OP_ADD..OP_ADDI, OP_NOP), reused by ALU and decode.
//  - wb_state_t enum {IDLE, WR_LO, WR_HI}.
//  - flags_t struct {c,v,z,n}.
//  - is_flag_op / is_write_op functions.
//  Single FSM plus hold registers; no sub-module needed.
// TESTING
//  1 Reset: rst_n=0 mid-WR_LO -> wb_valid=0, flags=0, retired=0 immediately (async).
//  2 ADD rd=3 result=16'h0007 flags 4'b0000, wb_ready=1 -> one write (3,0007) cycle after accept; retired=1.
//  3 MUL rd=15 result=16'h5678 result2=16'h1234:
//    - writes (15,5678) then (0,1234).
//    - in_ready=0 during WR_LO beat.
//  4 Back-pressure: SUB rd=2 result=16'hFFFF (N=1), wb_ready low 3 cycles ->
//    - wb_data held at FFFF for 4 cycles, in_ready=0 throughout.
//    - flags=4'b0001 from the cycle after accept.
//  5 Streaming: 4 back-to-back ADDI rd=1..4, wb_ready=1 -> 4 consecutive writes, retired=4.
//  6 NOP then opcode 8'h7F -> no wb_valid, flags unchanged, illegal_op=1 sticky, retired=2.

Source files
------------

// File: rtl/ubio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ubio_pkg
//  Description : Shared uBio definitions: ALU opcodes, writeback FSM state
//                encoding, architectural flag layout and opcode classifiers.
//  Revision    : 1.0  initial release
// ============================================================================
package ubio_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ORI  = 8'h0A;
  localparam logic [7:0] OP_ANDI = 8'h0C;
  localparam logic [7:0] OP_ADD  = 8'h12;
  localparam logic [7:0] OP_SUB  = 8'h13;
  localparam logic [7:0] OP_MUL  = 8'h14;
  localparam logic [7:0] OP_ADDI = 8'h15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } flags_t;

  // Ops that produce a register-file write.
  function automatic logic is_write_op(input logic [7:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_ORI, OP_ANDI, OP_ADDI};
  endfunction

  // Ops that load the architectural flags. Today this is the same set as the
  // writing ops, but the two are kept apart so decode can diverge later.
  function automatic logic is_flag_op(input logic [7:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_ORI, OP_ANDI, OP_ADDI};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_writeback_if
//  Description : Bundle between the ALU, the writeback stage and the
//                register-file write port.
//                ALU side : in_valid/in_ready, alu_ctl, rd_addr, result,
//                           result2, c_in/v_in/z_in/n_in
//                RF side  : wb_valid/wb_ready, wb_addr, wb_data
//                Status   : flags {C,V,Z,N}, illegal_op, retired
//                master = environment (ALU + register file), slave = stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_writeback_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        alu_ctl;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] result2;
  logic              c_in;
  logic              v_in;
  logic              z_in;
  logic              n_in;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [3:0]        flags;
  logic              illegal_op;
  logic [CNT_W-1:0]  retired;

  modport master (
    output in_valid, alu_ctl, rd_addr, result, result2,
           c_in, v_in, z_in, n_in, wb_ready,
    input  in_ready, wb_valid, wb_addr, wb_data, flags, illegal_op, retired
  );

  modport slave (
    input  in_valid, alu_ctl, rd_addr, result, result2,
           c_in, v_in, z_in, n_in, wb_ready,
    output in_ready, wb_valid, wb_addr, wb_data, flags, illegal_op, retired
  );
endinterface
`default_nettype wire

// File: rtl/alu_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : alu_writeback
//  Description : Execute->writeback stage behind the uBio ALU. Registers one
//                ALU result per accepted op and presents it to the register
//                file over wb_valid/wb_ready; MUL writes rd then rd+1. Holds
//                the {C,V,Z,N} flags, a sticky illegal-opcode bit and a
//                wrapping retired-op counter.
//  Ports       : clk, rst_n (async, active low), bus (alu_writeback_if.slave)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_writeback
  import ubio_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_writeback_if.slave bus
);

  wb_state_t         state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] res2_q, res2_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  flags_t            flags_q, flags_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic       mul_held;
  logic       lo_done;
  logic       hi_done;
  logic       in_ready;
  logic       accept;
  logic       acc_write;
  logic       acc_other;
  logic [1:0] retire_inc;

  // Handshake decode
  assign mul_held  = (op_q == OP_MUL);
  assign lo_done   = (state_q == WR_LO) && bus.wb_ready && !mul_held;
  assign hi_done   = (state_q == WR_HI) && bus.wb_ready;
  // Gated by rst_n so the ALU sees no ready while reset is asserted.
  assign in_ready  = rst_n && ((state_q == IDLE) || lo_done || hi_done);
  assign accept    = bus.in_valid && in_ready;
  assign acc_write = accept && is_write_op(bus.alu_ctl);
  assign acc_other = accept && !is_write_op(bus.alu_ctl);

  // A finishing write and an accepted NOP/illegal op are two separate
  // completions, so both count when they land in the same cycle.
  assign retire_inc = {1'b0, (lo_done || hi_done)} + {1'b0, acc_other};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (acc_write) state_d = WR_LO;
      WR_LO: begin
        if (bus.wb_ready) begin
          if (mul_held)       state_d = WR_HI;
          else if (acc_write) state_d = WR_LO;
          else                state_d = IDLE;
        end
      end
      WR_HI: begin
        if (bus.wb_ready) state_d = acc_write ? WR_LO : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold registers, write port and status next-values
  always_comb begin
    op_d      = op_q;
    rd_d      = rd_q;
    res2_d    = res2_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    retired_d = retired_q + CNT_W'(retire_inc);

    if (accept) begin
      op_d   = bus.alu_ctl;
      rd_d   = bus.rd_addr;
      res2_d = bus.result2;
    end

    // The low result goes straight into the write-port register; the high
    // half waits in res2_q until the low beat is taken.
    if (acc_write) begin
      wb_addr_d = bus.rd_addr;
      wb_data_d = bus.result;
    end else if ((state_q == WR_LO) && bus.wb_ready && mul_held) begin
      wb_addr_d = rd_q + ADDR_W'(1);
      wb_data_d = res2_q;
    end

    if (accept && is_flag_op(bus.alu_ctl))
      flags_d = '{c: bus.c_in, v: bus.v_in, z: bus.z_in, n: bus.n_in};

    if (acc_other && (bus.alu_ctl != OP_NOP))
      illegal_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_NOP;
      rd_q      <= '0;
      res2_q    <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      op_q      <= op_d;
      rd_q      <= rd_d;
      res2_q    <= res2_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Outputs
  always_comb begin
    bus.wb_valid   = (state_q != IDLE);
    bus.in_ready   = in_ready;
    bus.wb_addr    = wb_addr_q;
    bus.wb_data    = wb_data_q;
    bus.flags      = flags_q;
    bus.illegal_op = illegal_q;
    bus.retired    = retired_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_writeback
//  Description : Self-checking bench for alu_writeback: directed scenarios
//                plus randomized traffic against a queue-based write model.
//                The retired counter is built 4 bits wide here so that its
//                wrap is reached in a handful of cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_writeback;

  localparam int TB_CNT_W = 4;

  localparam logic [7:0] T_NOP  = 8'h00;
  localparam logic [7:0] T_ORI  = 8'h0A;
  localparam logic [7:0] T_ANDI = 8'h0C;
  localparam logic [7:0] T_ADD  = 8'h12;
  localparam logic [7:0] T_SUB  = 8'h13;
  localparam logic [7:0] T_MUL  = 8'h14;
  localparam logic [7:0] T_ADDI = 8'h15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_writeback_if #(.DATA_W(16), .ADDR_W(4), .CNT_W(TB_CNT_W)) bus ();

  alu_writeback #(.DATA_W(16), .ADDR_W(4), .CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic drive(input logic v, input logic [7:0] op, input logic [3:0] rd,
                       input logic [15:0] r, input logic [15:0] r2,
                       input logic [3:0] f, input logic rdy);
    bus.in_valid = v;
    bus.alu_ctl  = op;
    bus.rd_addr  = rd;
    bus.result   = r;
    bus.result2  = r2;
    {bus.c_in, bus.v_in, bus.z_in, bus.n_in} = f;
    bus.wb_ready = rdy;
  endtask

  // ---------------------------------------------------------------- reset --
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, T_NOP, 4'd0, 16'h0, 16'h0, 4'h0, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.in_ready   !== 1'b0)  begin errors++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
    checks++; if (bus.wb_valid   !== 1'b0)  begin errors++; $display("FAIL rst_wb_valid got %b exp 0", bus.wb_valid); end
    checks++; if (bus.wb_addr    !== 4'h0)  begin errors++; $display("FAIL rst_wb_addr got %h exp 0", bus.wb_addr); end
    checks++; if (bus.wb_data    !== 16'h0) begin errors++; $display("FAIL rst_wb_data got %h exp 0", bus.wb_data); end
    checks++; if (bus.flags      !== 4'h0)  begin errors++; $display("FAIL rst_flags got %b exp 0000", bus.flags); end
    checks++; if (bus.illegal_op !== 1'b0)  begin errors++; $display("FAIL rst_illegal got %b exp 0", bus.illegal_op); end
    checks++; if (bus.retired    !== 4'h0)  begin errors++; $display("FAIL rst_retired got %0d exp 0", bus.retired); end

    // Build up non-reset state, then pull reset in the middle of a MUL.
    @(negedge clk); rst_n = 1'b1;
    drive(1'b1, 8'h7F, 4'd0, 16'h0, 16'h0, 4'h0, 1'b1);
    @(negedge clk);
    drive(1'b1, T_MUL, 4'd5, 16'hAAAA, 16'hBBBB, 4'hF, 1'b0);
    @(negedge clk);
    drive(1'b0, T_NOP, 4'd0, 16'h0, 16'h0, 4'h0, 1'b0);
    #1;
    checks++; if (bus.wb_valid   !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got %b exp 1", bus.wb_valid); end
    checks++; if (bus.retired    !== 4'd1) begin errors++; $display("FAIL pre_rst_retired got %0d exp 1", bus.retired); end
    checks++; if (bus.flags      !== 4'hF) begin errors++; $display("FAIL pre_rst_flags got %b exp 1111", bus.flags); end
    checks++; if (bus.illegal_op !== 1'b1) begin errors++; $display("FAIL pre_rst_illegal got %b exp 1", bus.illegal_op); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.wb_valid   !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %b exp 0", bus.wb_valid); end
    checks++; if (bus.flags      !== 4'h0) begin errors++; $display("FAIL async_rst_flags got %b exp 0000", bus.flags); end
    checks++; if (bus.retired    !== 4'd0) begin errors++; $display("FAIL async_rst_retired got %0d exp 0", bus.retired); end
    checks++; if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL async_rst_illegal got %b exp 0", bus.illegal_op); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL post_rst_no_hi got %b exp 0 (cycle %0d)", bus.wb_valid, i); end
    end
    @(negedge clk);
  endtask

  // ------------------------------------------------------------------ ADD --
  task automatic test_add();
    drive(1'b1, T_ADD, 4'd3, 16'h0007, 16'h0, 4'b0000, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got %b exp 1", bus.in_ready); end
    @(negedge clk);
    drive(1'b0, T_NOP, 4'd0, 16'h0, 16'h0, 4'h0, 1'b1);
    #1;
    checks++; if (bus.wb_valid !== 1'b1)     begin errors++; $display("FAIL add_valid got %b exp 1", bus.wb_valid); end
    checks++; if (bus.wb_addr  !== 4'd3)     begin errors++; $display("FAIL add_addr got %h exp 3", bus.wb_addr); end
    checks++; if (bus.wb_data  !== 16'h0007) begin errors++; $display("FAIL add_data got %h exp 0007", bus.wb_data); end
    checks++; if (bus.flags    !== 4'b0000)  begin errors++; $display("FAIL add_flags got %b exp 0000", bus.flags); end
    @(negedge clk); #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL add_done_valid got %b exp 0", bus.wb_valid); end
    checks++; if (bus.retired  !== 4'd1) begin errors++; $display("FAIL add_retired got %0d exp 1", bus.retired); end
  endtask

  // ------------------------------------------------------------------ MUL --
  task automatic test_mul();
    drive(1'b1, T_MUL, 4'd15, 16'h5678, 16'h1234, 4'b1010, 1'b1);
    @(negedge clk);
    drive(1'b0, T_NOP, 4'd0, 16'h0, 16'h0, 4'h0, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 1'b0)     begin errors++; $display("FAIL mul_lo_in_ready got %b exp 0", bus.in_ready); end
    checks++; if (bus.wb_valid !== 1'b1)     begin errors++; $display("FAIL mul_lo_valid got %b exp 1", bus.wb_valid); end
    checks++; if (bus.wb_addr  !== 4'd15)    begin errors++; $display("FAIL mul_lo_addr got %h exp f", bus.wb_addr); end
    checks++; if (bus.wb_data  !== 16'h5678) begin errors++; $display("FAIL mul_lo_data got %h exp 5678", bus.wb_data); end
    checks++; if (bus.flags    !== 4'b1010)  begin errors++; $display("FAIL mul_flags got %b exp 1010", bus.flags); end
    @(negedge clk); #1;
    checks++; if (bus.wb_valid !== 1'b1)     begin errors++; $display("FAIL mul_hi_valid got %b exp 1", bus.wb_valid); end
    checks++; if (bus.wb_addr  !== 4'd0)     begin errors++; $display("FAIL mul_hi_addr got %h exp 0", bus.wb_addr); end
    checks++; if (bus.wb_data  !== 16'h1234) begin errors++; $display("FAIL mul_hi_data got %h exp 1234", bus.wb_data); end
    checks++; if (bus.in_ready !== 1'b1)     begin errors++; $display("FAIL mul_hi_in_ready got %b exp 1", bus.in_ready); end
    @(negedge clk); #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL mul_done_valid got %b exp 0", bus.wb_valid); end
    checks++; if (bus.retired  !== 4'd2) begin errors++; $display("FAIL mul_retired got %0d exp 2", bus.retired); end
  endtask

  // --------------------------------------------------------- back-pressure --
  task automatic test_backpressure();
    drive(1'b1, T_SUB, 4'd2, 16'hFFFF, 16'h0, 4'b0001, 1'b0);
    @(negedge clk);
    drive(1'b0, T_NOP, 4'd0, 16'h0, 16'h0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.wb_ready = 1'b1;
      #1;
      checks++; if (bus.wb_valid !== 1'b1)     begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, bus.wb_valid); end
      checks++; if (bus.wb_addr  !== 4'd2)     begin errors++; $display("FAIL bp_addr[%0d] got %h exp 2", i, bus.wb_addr); end
      checks++; if (bus.wb_data  !== 16'hFFFF) begin errors++; $display("FAIL bp_data[%0d] got %h exp ffff", i, bus.wb_data); end
      checks++; if (bus.flags    !== 4'b0001)  begin errors++; $display("FAIL bp_flags[%0d] got %b exp 0001", i, bus.flags); end
      if (i < 3) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, bus.in_ready); end
      end
      @(negedge clk);
    end
    #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL bp_done_valid got %b exp 0", bus.wb_valid); end
    checks++; if (bus.retired  !== 4'd3) begin errors++; $display("FAIL bp_retired got %0d exp 3", bus.retired); end
  endtask

  // ------------------------------------------------------------ streaming --
  task automatic test_back_to_back();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, T_ADDI, 4'(k), 16'h1000 + 16'(k), 16'h0, 4'(k), 1'b1);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", k, bus.in_ready); end
      if (k > 1) begin
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp 1", k - 1, bus.wb_valid); end
        checks++; if (bus.wb_addr !== 4'(k - 1)) begin errors++; $display("FAIL b2b_addr[%0d] got %h exp %h", k - 1, bus.wb_addr, 4'(k - 1)); end
        checks++; if (bus.wb_data !== 16'h1000 + 16'(k - 1)) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", k - 1, bus.wb_data, 16'h1000 + 16'(k - 1)); end
      end
      @(negedge clk);
    end
    drive(1'b0, T_NOP, 4'd0, 16'h0, 16'h0, 4'h0, 1'b1);
    #1;
    checks++; if (bus.wb_addr !== 4'd4)     begin errors++; $display("FAIL b2b_addr[4] got %h exp 4", bus.wb_addr); end
    checks++; if (bus.wb_data !== 16'h1004) begin errors++; $display("FAIL b2b_data[4] got %h exp 1004", bus.wb_data); end
    @(negedge clk); #1;
    checks++; if (bus.wb_valid !== 1'b0)    begin errors++; $display("FAIL b2b_done_valid got %b exp 0", bus.wb_valid); end
    checks++; if (bus.retired  !== 4'd7)    begin errors++; $display("FAIL b2b_retired got %0d exp 7", bus.retired); end
    checks++; if (bus.flags    !== 4'b0100) begin errors++; $display("FAIL b2b_flags got %b exp 0100", bus.flags); end
  endtask

  // ------------------------------------------------------ NOP / illegal op --
  task automatic test_nop_illegal();
    drive(1'b1, T_NOP, 4'd6, 16'hDEAD, 16'h0, 4'hF, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'h7F, 4'd6, 16'hBEEF, 16'h0, 4'hF, 1'b1);
    #1;
    checks++; if (bus.wb_valid   !== 1'b0)    begin errors++; $display("FAIL nop_valid got %b exp 0", bus.wb_valid); end
    checks++; if (bus.flags      !== 4'b0100) begin errors++; $display("FAIL nop_flags got %b exp 0100", bus.flags); end
    checks++; if (bus.illegal_op !== 1'b0)    begin errors++; $display("FAIL nop_illegal got %b exp 0", bus.illegal_op); end
    @(negedge clk);
    drive(1'b0, T_NOP, 4'd0, 16'h0, 16'h0, 4'h0, 1'b1);
    #1;
    checks++; if (bus.wb_valid   !== 1'b0)    begin errors++; $display("FAIL ill_valid got %b exp 0", bus.wb_valid); end
    checks++; if (bus.flags      !== 4'b0100) begin errors++; $display("FAIL ill_flags got %b exp 0100", bus.flags); end
    checks++; if (bus.illegal_op !== 1'b1)    begin errors++; $display("FAIL ill_set got %b exp 1", bus.illegal_op); end
    checks++; if (bus.retired    !== 4'd9)    begin errors++; $display("FAIL ill_retired got %0d exp 9", bus.retired); end
    drive(1'b1, T_NOP, 4'd0, 16'h0, 16'h0, 4'h0, 1'b1);
    @(negedge clk);
    drive(1'b0, T_NOP, 4'd0, 16'h0, 16'h0, 4'h0, 1'b1);
    #1;
    checks++; if (bus.illegal_op !== 1'b1) begin errors++; $display("FAIL ill_sticky got %b exp 1", bus.illegal_op); end
    checks++; if (bus.retired    !== 4'd10) begin errors++; $display("FAIL nop2_retired got %0d exp 10", bus.retired); end
  endtask

  // ------------------------------------------------------- retired wrap --
  task automatic test_retired_wrap();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, T_NOP, 4'd0, 16'h0, 16'h0, 4'h0, 1'b1);
      @(negedge clk);
    end
    drive(1'b0, T_NOP, 4'd0, 16'h0, 16'h0, 4'h0, 1'b1);
    #1;
    checks++; if (bus.retired !== 4'd15) begin errors++; $display("FAIL wrap_max got %0d exp 15", bus.retired); end
    drive(1'b1, T_NOP, 4'd0, 16'h0, 16'h0, 4'h0, 1'b1);
    @(negedge clk);
    drive(1'b0, T_NOP, 4'd0, 16'h0, 16'h0, 4'h0, 1'b1);
    #1;
    checks++; if (bus.retired !== 4'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", bus.retired); end
  endtask

  // --------------------------------------------------- randomized traffic --
  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    bit          last;
  } beat_t;

  function automatic bit m_writes(input logic [7:0] op);
    return (op == T_ADD) || (op == T_SUB) || (op == T_MUL) ||
           (op == T_ORI) || (op == T_ANDI) || (op == T_ADDI);
  endfunction

  task automatic test_random();
    beat_t       q[$];
    beat_t       b;
    int          m_ret     = 0;
    logic [3:0]  m_flags   = 4'h0;
    bit          m_ill     = 1'b0;
    bit          holding   = 1'b0;
    bit          exp_ready;
    bit          acc;
    logic [7:0]  ops[9];
    logic [7:0]  op;
    logic [3:0]  rd;
    logic [15:0] r, r2;
    logic [3:0]  f;

    ops = '{T_ADD, T_SUB, T_MUL, T_ORI, T_ANDI, T_ADDI, T_MUL, T_NOP, 8'h00};
    op = T_NOP; rd = 4'd0; r = 16'h0; r2 = 16'h0; f = 4'h0;

    rst_n = 1'b0;
    drive(1'b0, T_NOP, 4'd0, 16'h0, 16'h0, 4'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      checks++; if (bus.wb_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", cyc, bus.wb_valid, q.size() > 0); end
      if (q.size() > 0) begin
        checks++; if (bus.wb_addr !== q[0].addr) begin errors++; $display("FAIL rnd_addr[%0d] got %h exp %h", cyc, bus.wb_addr, q[0].addr); end
        checks++; if (bus.wb_data !== q[0].data) begin errors++; $display("FAIL rnd_data[%0d] got %h exp %h", cyc, bus.wb_data, q[0].data); end
      end
      checks++; if (bus.flags      !== m_flags)   begin errors++; $display("FAIL rnd_flags[%0d] got %b exp %b", cyc, bus.flags, m_flags); end
      checks++; if (bus.illegal_op !== m_ill)     begin errors++; $display("FAIL rnd_illegal[%0d] got %b exp %b", cyc, bus.illegal_op, m_ill); end
      checks++; if (bus.retired    !== m_ret[3:0]) begin errors++; $display("FAIL rnd_retired[%0d] got %0d exp %0d", cyc, bus.retired, m_ret[3:0]); end

      // Upstream keeps a stalled op stable until it is taken.
      if (!holding) begin
        op = ($urandom_range(0, 15) == 0) ? 8'($urandom) : ops[$urandom_range(0, 8)];
        rd = 4'($urandom); r = 16'($urandom); r2 = 16'($urandom); f = 4'($urandom);
        drive(($urandom_range(0, 3) != 0), op, rd, r, r2, f, 1'b0);
      end
      bus.wb_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = (q.size() == 0) || ((q.size() == 1) && bus.wb_ready);
      checks++; if (bus.in_ready !== exp_ready) begin errors++; $display("FAIL rnd_in_ready[%0d] got %b exp %b", cyc, bus.in_ready, exp_ready); end

      acc = bus.in_valid && exp_ready;
      if ((q.size() > 0) && bus.wb_ready) begin
        b = q.pop_front();
        if (b.last) m_ret++;
      end
      if (acc) begin
        if (m_writes(op)) begin
          m_flags = f;
          if (op == T_MUL) begin
            q.push_back('{addr: rd, data: r, last: 1'b0});
            q.push_back('{addr: rd + 4'd1, data: r2, last: 1'b1});
          end else begin
            q.push_back('{addr: rd, data: r, last: 1'b1});
          end
        end else begin
          m_ret++;
          if (op != T_NOP) m_ill = 1'b1;
        end
      end
      holding = bus.in_valid && !acc;
    end
  endtask

  initial begin
    drive(1'b0, T_NOP, 4'd0, 16'h0, 16'h0, 4'h0, 1'b0);
    test_reset();
    test_add();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_nop_illegal();
    test_retired_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
